// File: rtl/stripe_pkg.sv
// Definitions shared by the byte striper and its lane registers (and by the un-striper):
// FSM encoding, default byte width and lane indices.
package stripe_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

endpackage

// File: rtl/byte_striping_lane_reg.sv
// One output lane of the striper: registered byte, valid flag and a wrapping count of
// the valid bytes written to it.
module lane_reg
  import stripe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  // An invalid write slot clears the valid flag but never touches the held byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_wr_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/byte_striping.sv
// Splits a byte stream round-robin over two staggered lanes; an alignment FSM makes
// sure the first valid byte of every burst lands on lane_0.
module byte_striping
  import stripe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int IDLE_LIMIT = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              aligned,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1
);

  localparam int                IDLE_W   = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

  function automatic logic [IDLE_W-1:0] idle_sat_inc(input logic [IDLE_W-1:0] v);
    return (v == IDLE_MAX) ? v : v + IDLE_W'(1);
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_sel, w_sel_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [1:0]        w_wr_en;
  logic [1:0]        w_lane_vld;
  logic              w_exit;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state <= SYNC;
      r_sel   <= 1'b0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // Leaving ACTIVE only on a lane_0 slot keeps every burst fully paired.
  assign w_exit = (r_idle == IDLE_MAX) && !r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idle_nxt  = r_idle;
    w_wr_en     = 2'b00;
    w_lane_vld  = 2'b00;
    case (r_state)
      SYNC: begin
        w_wr_en[LANE0]    = 1'b1;
        w_wr_en[LANE1]    = 1'b1;
        w_lane_vld[LANE0] = valid_in;
        w_sel_nxt         = 1'b0;
        w_idle_nxt        = '0;
        if (valid_in) begin
          w_state_nxt = ACTIVE;
          w_sel_nxt   = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_exit) begin
          w_state_nxt       = SYNC;
          w_sel_nxt         = 1'b0;
          w_idle_nxt        = '0;
          w_wr_en[LANE0]    = 1'b1;
          w_lane_vld[LANE0] = 1'b0;
        end else begin
          w_wr_en[r_sel]    = 1'b1;
          w_lane_vld[r_sel] = valid_in;
          w_sel_nxt         = ~r_sel;
          w_idle_nxt        = valid_in ? '0 : idle_sat_inc(r_idle);
        end
      end
    endcase
  end

  lane_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane0 (
    .i_clk   (clk_2f),
    .i_rst   (reset),
    .i_wr_en (w_wr_en[LANE0]),
    .i_valid (w_lane_vld[LANE0]),
    .i_data  (data_in),
    .o_data  (lane_0),
    .o_valid (valid_0),
    .o_cnt   (cnt_0)
  );

  lane_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane1 (
    .i_clk   (clk_2f),
    .i_rst   (reset),
    .i_wr_en (w_wr_en[LANE1]),
    .i_valid (w_lane_vld[LANE1]),
    .i_data  (data_in),
    .o_data  (lane_1),
    .o_valid (valid_1),
    .o_cnt   (cnt_1)
  );

  // The state flop doubles as the alignment flag.
  assign aligned = (r_state == ACTIVE);

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping: a behavioural model queues the expected outputs for
// every driven cycle; each test pops and compares them, plus hand-derived spot checks.
module tb_byte_striping;

  localparam int DW = 8;
  localparam int IL = 4;
  localparam int CW = 4;

  logic          clk_2f = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] lane_0, lane_1;
  logic          valid_0, valid_1, aligned;
  logic [CW-1:0] cnt_0, cnt_1;

  byte_striping #(.DATA_W(DW), .IDLE_LIMIT(IL), .CNT_W(CW)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .lane_0   (lane_0),
    .lane_1   (lane_1),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .aligned  (aligned),
    .cnt_0    (cnt_0),
    .cnt_1    (cnt_1)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct packed {
    logic [DW-1:0] l0;
    logic [DW-1:0] l1;
    logic          v0;
    logic          v1;
    logic          al;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o, got_o;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model of the striper, written from the behavioural description.
  logic          m_active = 1'b0;
  logic          m_sel    = 1'b0;
  int            m_idle   = 0;
  logic [DW-1:0] m_l0 = '0, m_l1 = '0;
  logic          m_v0 = 1'b0, m_v1 = 1'b0;
  logic [CW-1:0] m_c0 = '0, m_c1 = '0;

  task automatic model_step(input logic r, input logic [DW-1:0] d, input logic v);
    if (r) begin
      m_active = 1'b0; m_sel = 1'b0; m_idle = 0;
      m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_c0 = '0; m_c1 = '0;
    end else if (!m_active) begin
      m_v1 = 1'b0;
      m_v0 = v;
      if (v) begin
        m_l0 = d; m_c0 = m_c0 + 1'b1; m_sel = 1'b1; m_active = 1'b1;
      end
    end else if (m_idle == IL && !m_sel) begin
      m_active = 1'b0; m_v0 = 1'b0; m_sel = 1'b0; m_idle = 0;
    end else begin
      if (!m_sel) begin
        m_v0 = v;
        if (v) begin m_l0 = d; m_c0 = m_c0 + 1'b1; end
      end else begin
        m_v1 = v;
        if (v) begin m_l1 = d; m_c1 = m_c1 + 1'b1; end
      end
      m_sel  = !m_sel;
      m_idle = v ? 0 : ((m_idle < IL) ? m_idle + 1 : IL);
    end
  endtask

  task automatic drive(input logic r, input logic [DW-1:0] d, input logic v);
    obs_t e;
    reset = r; data_in = d; valid_in = v;
    model_step(r, d, v);
    e = '{l0: m_l0, l1: m_l1, v0: m_v0, v1: m_v1, al: m_active, c0: m_c0, c1: m_c1};
    sb.push_back(e);
    @(posedge clk_2f);
    #1;
  endtask

  function automatic obs_t sample();
    return '{l0: lane_0, l1: lane_1, v0: valid_0, v1: valid_1, al: aligned, c0: cnt_0, c1: cnt_1};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA4, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL reset_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
    end
    n_checks++;
    if ({lane_0, lane_1, valid_0, valid_1, aligned, cnt_0, cnt_1} !== '0)
      $display("FAIL reset_zero got %h want 0", {lane_0, lane_1, valid_0, valid_1, aligned, cnt_0, cnt_1});
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [DW-1:0] tbl [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
    logic [31:0]   got, want;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, tbl[i], 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL burst_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
      case (i)
        0:       begin got = {22'd0, lane_0, valid_0, aligned}; want = {22'd0, 8'hFF, 1'b1, 1'b1}; end
        1:       begin got = {23'd0, lane_1, valid_1};          want = {23'd0, 8'hEE, 1'b1}; end
        2:       begin got = {23'd0, lane_0, valid_0};          want = {23'd0, 8'hDD, 1'b1}; end
        default: begin got = {16'd0, lane_1, cnt_0, cnt_1};     want = {16'd0, 8'hCC, 4'd2, 4'd2}; end
      endcase
      n_checks++;
      if (got !== want) $display("FAIL burst_spot[%0d] got %h want %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] dat [4] = '{8'h7F, 8'h7D, 8'h03, 8'h04};
    logic          vld [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0]    want [4] = '{{1'b0, 8'hDD}, {1'b0, 8'hCC}, {1'b1, 8'h03}, {1'b1, 8'h04}};
    logic [8:0]    got;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, dat[i], vld[i]);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL gaps_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
      got = (i % 2 == 0) ? {valid_0, lane_0} : {valid_1, lane_1};
      n_checks++;
      if (got !== want[i]) $display("FAIL gaps_spot[%0d] got %h want %h", i, got, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_realign();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'(8'h10 + i), 1'b0);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL realign_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
      if (i == 3 || i == 4) begin
        n_checks++;
        if (aligned !== (i == 3)) $display("FAIL realign_aligned[%0d] got %b want %b", i, aligned, (i == 3));
        else n_pass++;
      end
    end
    drive(1'b0, 8'h99, 1'b1);
    exp_o = sb.pop_front(); got_o = sample(); n_checks++;
    if (got_o !== exp_o) $display("FAIL realign_sb_99 got %h want %h", got_o, exp_o);
    else n_pass++;
    n_checks++;
    if ({lane_0, valid_0, aligned} !== {8'h99, 1'b1, 1'b1})
      $display("FAIL realign_99 got %h want %h", {lane_0, valid_0, aligned}, {8'h99, 1'b1, 1'b1});
    else n_pass++;
  endtask

  // After 99 the next slot is lane_1, so the limit is first reached on a lane_1 slot.
  task automatic test_realign_odd();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'(8'h20 + i), 1'b0);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL odd_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
      if (i >= 4) begin
        n_checks++;
        if (aligned !== (i == 4)) $display("FAIL odd_aligned[%0d] got %b want %b", i, aligned, (i == 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_midreset();
    drive(1'b0, 8'h07, 1'b1);
    exp_o = sb.pop_front(); got_o = sample(); n_checks++;
    if (got_o !== exp_o) $display("FAIL midrst_sb_07 got %h want %h", got_o, exp_o);
    else n_pass++;
    drive(1'b1, 8'h08, 1'b1);
    exp_o = sb.pop_front(); got_o = sample(); n_checks++;
    if (got_o !== exp_o) $display("FAIL midrst_sb_08 got %h want %h", got_o, exp_o);
    else n_pass++;
    n_checks++;
    if (got_o !== '0) $display("FAIL midrst_zero got %h want 0", got_o);
    else n_pass++;
    drive(1'b0, 8'h62, 1'b1);
    exp_o = sb.pop_front(); got_o = sample(); n_checks++;
    if (got_o !== exp_o) $display("FAIL midrst_sb_62 got %h want %h", got_o, exp_o);
    else n_pass++;
    n_checks++;
    if ({lane_0, valid_0, lane_1, valid_1, aligned} !== {8'h62, 1'b1, 8'h00, 1'b0, 1'b1})
      $display("FAIL midrst_62 got %h want %h", {lane_0, valid_0, lane_1, valid_1, aligned},
               {8'h62, 1'b1, 8'h00, 1'b0, 1'b1});
    else n_pass++;
  endtask

  task automatic test_back_to_back_wrap();
    drive(1'b1, 8'h00, 1'b0);
    exp_o = sb.pop_front(); got_o = sample(); n_checks++;
    if (got_o !== exp_o) $display("FAIL wrap_rst got %h want %h", got_o, exp_o);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); n_checks++;
      if (got_o !== exp_o) $display("FAIL wrap_sb[%0d] got %h want %h", i, got_o, exp_o);
      else n_pass++;
      if (i == 30) begin
        n_checks++;
        if ({cnt_0, cnt_1} !== {4'd0, 4'd15}) $display("FAIL wrap_31 got %h want %h", {cnt_0, cnt_1}, {4'd0, 4'd15});
        else n_pass++;
      end
    end
    n_checks++;
    if ({cnt_0, cnt_1, valid_0, valid_1, aligned} !== {4'd0, 4'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL wrap_32 got %h want %h", {cnt_0, cnt_1, valid_0, valid_1, aligned},
               {4'd0, 4'd0, 1'b1, 1'b1, 1'b1});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; data_in = '0; valid_in = 1'b0;
    test_reset();
    test_burst();
    test_gaps();
    test_realign();
    test_realign_odd();
    test_midreset();
    test_back_to_back_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
